// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite register responder: response codes,
// fixed register indices, error read data, FSM state types and a byte-merge helper.
package axi_lite_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam int REG_ID      = 0;
    localparam int REG_SCRATCH = 1;
    localparam int REG_CYCLES  = 2;
    localparam int REG_WRCNT   = 3;

    localparam logic [31:0] RD_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    // Replace only the bytes whose strobe bit is set
    function automatic logic [31:0] merge_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_reg_responder_if.sv
// AXI4-Lite bus bundle between the bridge (master) and the register responder (slave).
interface axi_lite_reg_responder_if #(parameter int ADDR_WIDTH = 32);

    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_wr_ctrl.sv
// Write channel controller: latches AW and W independently, emits a one-cycle
// commit (index, data, strobe) once both are present, then runs the B handshake.
module axi_lite_wr_ctrl
    import axi_lite_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 5
) (
    input  logic             s_aclk,
    input  logic             s_aresetn,
    input  logic [IDX_W-1:0] i_aw_idx,
    input  logic             i_awvalid,
    output logic             o_awready,
    input  logic [31:0]      i_wdata,
    input  logic [3:0]       i_wstrb,
    input  logic             i_wvalid,
    output logic             o_wready,
    output logic [1:0]       o_bresp,
    output logic             o_bvalid,
    input  logic             i_bready,
    output logic             o_commit,
    output logic [IDX_W-1:0] o_cm_idx,
    output logic [31:0]      o_cm_data,
    output logic [3:0]       o_cm_strb
);

    wr_state_t        r_state;
    logic             r_awready;
    logic             r_wready;
    logic             r_bvalid;
    logic [1:0]       r_bresp;
    logic             r_aw_held;
    logic             r_w_held;
    logic [IDX_W-1:0] r_aw_idx;
    logic [31:0]      r_wdata;
    logic [3:0]       r_wstrb;

    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_commit;
    logic             w_cm_err;

    assign w_aw_hs  = i_awvalid & r_awready;
    assign w_w_hs   = i_wvalid & r_wready;
    // A channel counts as present if it was latched earlier or is being accepted now
    assign w_commit = (r_state == WR_IDLE) & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);

    assign o_cm_idx  = r_aw_held ? r_aw_idx : i_aw_idx;
    assign o_cm_data = r_w_held  ? r_wdata  : i_wdata;
    assign o_cm_strb = r_w_held  ? r_wstrb  : i_wstrb;
    assign w_cm_err  = (32'(o_cm_idx) >= NUM_REGS);

    assign o_commit  = w_commit;
    assign o_awready = r_awready;
    assign o_wready  = r_wready;
    assign o_bvalid  = r_bvalid;
    assign o_bresp   = r_bresp;

    // Write FSM: collect AW/W in WR_IDLE, hold B in WR_RESP until bready
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            r_state   <= WR_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= AXI_RESP_OKAY;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            case (r_state)
                WR_IDLE: begin
                    if (w_commit) begin
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_cm_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        r_state   <= WR_RESP;
                    end else begin
                        // Readies rise on the first cycle out of reset and drop once latched
                        if (w_aw_hs) begin
                            r_aw_held <= 1'b1;
                            r_aw_idx  <= i_aw_idx;
                            r_awready <= 1'b0;
                        end else if (!r_aw_held) begin
                            r_awready <= 1'b1;
                        end
                        if (w_w_hs) begin
                            r_w_held  <= 1'b1;
                            r_wdata   <= i_wdata;
                            r_wstrb   <= i_wstrb;
                            r_wready  <= 1'b0;
                        end else if (!r_w_held) begin
                            r_wready  <= 1'b1;
                        end
                    end
                end
                WR_RESP: begin
                    if (i_bready) begin
                        r_bvalid  <= 1'b0;
                        r_bresp   <= AXI_RESP_OKAY;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_state   <= WR_IDLE;
                    end
                end
                default: r_state <= WR_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite register bank: ID, scratch, cycle counter, write counter and general
// RW registers. Write path lives in axi_lite_wr_ctrl; the read FSM lives here.
module axi_lite_reg_responder
    import axi_lite_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          NUM_REGS   = 16,
    parameter logic [31:0] ID_VALUE   = 32'hAC70_1B01
) (
    input  logic                     s_aclk,
    input  logic                     s_aresetn,
    axi_lite_reg_responder_if.slave  s_axi
);

    // Array select width, plus a decoded index one bit wider when NUM_REGS is a
    // power of two so the first range above the bank (e.g. 0x40 for 16 regs)
    // decodes as out of range instead of aliasing onto register 0.
    localparam int ARR_W = $clog2(NUM_REGS);
    localparam int IDX_W = $clog2(NUM_REGS + 1);

    logic [31:0]      w_reg_val [NUM_REGS];
    logic             w_commit;
    logic [IDX_W-1:0] w_cm_idx;
    logic [31:0]      w_cm_data;
    logic [3:0]       w_cm_strb;

    logic [IDX_W-1:0] w_ar_idx;
    logic             w_ar_err;
    logic [31:0]      w_rd_val;
    logic             w_unused_addr_bits;

    rd_state_t        r_rd_state;
    logic             r_arready;
    logic             r_rvalid;
    logic [31:0]      r_rdata;
    logic [1:0]       r_rresp;

    assign w_unused_addr_bits = ^{s_axi.awaddr[ADDR_WIDTH-1:IDX_W+2], s_axi.awaddr[1:0],
                                  s_axi.araddr[ADDR_WIDTH-1:IDX_W+2], s_axi.araddr[1:0]};

    axi_lite_wr_ctrl #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_wr_ctrl (
        .s_aclk    (s_aclk),
        .s_aresetn (s_aresetn),
        .i_aw_idx  (s_axi.awaddr[IDX_W+1:2]),
        .i_awvalid (s_axi.awvalid),
        .o_awready (s_axi.awready),
        .i_wdata   (s_axi.wdata),
        .i_wstrb   (s_axi.wstrb),
        .i_wvalid  (s_axi.wvalid),
        .o_wready  (s_axi.wready),
        .o_bresp   (s_axi.bresp),
        .o_bvalid  (s_axi.bvalid),
        .i_bready  (s_axi.bready),
        .o_commit  (w_commit),
        .o_cm_idx  (w_cm_idx),
        .o_cm_data (w_cm_data),
        .o_cm_strb (w_cm_strb)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == REG_ID) begin : g_id
                assign w_reg_val[gi] = ID_VALUE;
            end else if (gi == REG_CYCLES) begin : g_cycles
                logic [31:0] r_cycles;
                // Free-running clock counter, wraps naturally
                always_ff @(posedge s_aclk or negedge s_aresetn) begin
                    if (!s_aresetn) r_cycles <= '0;
                    else            r_cycles <= r_cycles + 32'd1;
                end
                assign w_reg_val[gi] = r_cycles;
            end else if (gi == REG_WRCNT) begin : g_wrcnt
                logic [31:0] r_wrcnt;
                // Count every committed write, including out-of-range ones
                always_ff @(posedge s_aclk or negedge s_aresetn) begin
                    if (!s_aresetn)    r_wrcnt <= '0;
                    else if (w_commit) r_wrcnt <= r_wrcnt + 32'd1;
                end
                assign w_reg_val[gi] = r_wrcnt;
            end else begin : g_rw
                logic [31:0] r_val;
                // Byte-merge the committed data when this index is addressed
                always_ff @(posedge s_aclk or negedge s_aresetn) begin
                    if (!s_aresetn)
                        r_val <= '0;
                    else if (w_commit && (w_cm_idx == IDX_W'(gi)))
                        r_val <= merge_wstrb(r_val, w_cm_data, w_cm_strb);
                end
                assign w_reg_val[gi] = r_val;
            end
        end
    endgenerate

    assign w_ar_idx = s_axi.araddr[IDX_W+1:2];
    assign w_ar_err = (32'(w_ar_idx) >= NUM_REGS);
    assign w_rd_val = w_reg_val[w_ar_idx[ARR_W-1:0]];

    // Read FSM: sample data on the AR handshake, hold R until rready
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            r_rd_state <= RD_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= AXI_RESP_OKAY;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (!r_arready) begin
                        r_arready <= 1'b1;
                    end else if (s_axi.arvalid) begin
                        r_rdata    <= w_ar_err ? RD_ERR_DATA : w_rd_val;
                        r_rresp    <= w_ar_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        r_rvalid   <= 1'b1;
                        r_arready  <= 1'b0;
                        r_rd_state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (s_axi.rready) begin
                        r_rvalid   <= 1'b0;
                        r_arready  <= 1'b1;
                        r_rd_state <= RD_IDLE;
                    end
                end
                default: r_rd_state <= RD_IDLE;
            endcase
        end
    end

    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = r_rresp;

endmodule
